// File: rtl/mdio_phy_responder_if.sv
// MDIO pad and write-notification bundle between a management master (or bench)
// and the mdio_phy_responder PHY model.
interface mdio_phy_responder_if;
  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic        wr_valid;
  logic [4:0]  wr_regad;
  logic [15:0] wr_data;
  logic [15:0] ctrl_reg;

  modport master (
    output mdc, mdio_i,
    input  mdio_o, mdio_oe, wr_valid, wr_regad, wr_data, ctrl_reg
  );

  modport slave (
    input  mdc, mdio_i,
    output mdio_o, mdio_oe, wr_valid, wr_regad, wr_data, ctrl_reg
  );
endinterface

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY responder with a 32 x 16 register file, MDC oversampled in clk.
// Optional MDIO_PREAMBLE_CHECK_EN: require 32 preamble ones instead of preamble suppression.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR   = 5'd1,
  parameter logic [15:0] PHY_ID1    = 16'h0141,
  parameter logic [15:0] PHY_ID2    = 16'h0CC2,
  parameter logic [15:0] STATUS_VAL = 16'h796D,
  parameter logic [15:0] CTRL_RST   = 16'h1140
) (
  input  logic              clk,
  input  logic              reset_n,
  mdio_phy_responder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ST2, OP, PHYAD, REGAD, TA, DATA} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [5:0]  pre_cnt_reg, pre_cnt_next;
  logic [1:0]  op_reg, op_next;
  logic [4:0]  phyad_reg, phyad_next;
  logic [4:0]  regad_reg, regad_next;
  logic [15:0] data_sh_reg, data_sh_next;
  logic [15:0] rd_sh_reg, rd_sh_next;
  logic        mdio_o_reg, mdio_o_next;
  logic        mdio_oe_reg, mdio_oe_next;
  logic        wr_valid_reg, wr_valid_next;
  logic [4:0]  wr_regad_reg, wr_regad_next;
  logic [15:0] wr_data_reg, wr_data_next;

  logic [2:0]  mdc_sync_reg;
  logic [1:0]  mdio_sync_reg;
  logic        mdc_rise, mdio_bit, pre_ok, match;
  logic        commit, soft_rst;
  logic [15:0] commit_data;
  logic [15:0] reg_file [32];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdc_sync_reg  <= 3'b000;
      mdio_sync_reg <= 2'b11;
    end else begin
      mdc_sync_reg  <= {mdc_sync_reg[1:0], bus.mdc};
      mdio_sync_reg <= {mdio_sync_reg[0], bus.mdio_i};
    end
  end

  assign mdc_rise = mdc_sync_reg[1] & ~mdc_sync_reg[2];
  assign mdio_bit = mdio_sync_reg[1];
  assign match    = (phyad_reg == PHY_ADDR);

`ifdef MDIO_PREAMBLE_CHECK_EN
  assign pre_ok = pre_cnt_reg[5];
`else
  assign pre_ok = (pre_cnt_reg != 6'd0);
`endif

  // Registers 1-3 are hard-wired; the rest are flops so a soft reset can restore them at once.
  assign soft_rst = commit && (regad_reg == 5'd0) && commit_data[15];

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_reg
      if (gi >= 1 && gi <= 3) begin : g_ro
        assign reg_file[gi] = (gi == 1) ? STATUS_VAL : (gi == 2) ? PHY_ID1 : PHY_ID2;
      end else begin : g_rw
        localparam logic [15:0] RST_VAL = (gi == 0) ? CTRL_RST : 16'h0000;
        localparam logic [15:0] WR_MASK = (gi == 0) ? 16'h7FFF : 16'hFFFF;
        logic [15:0] val_reg;
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n)
            val_reg <= RST_VAL;
          else if (soft_rst)
            val_reg <= RST_VAL;
          else if (commit && (regad_reg == 5'(gi)))
            val_reg <= commit_data & WR_MASK;
        end
        assign reg_file[gi] = val_reg;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= 4'd0;
      pre_cnt_reg  <= 6'd0;
      op_reg       <= 2'b00;
      phyad_reg    <= 5'd0;
      regad_reg    <= 5'd0;
      data_sh_reg  <= 16'h0000;
      rd_sh_reg    <= 16'h0000;
      mdio_o_reg   <= 1'b1;
      mdio_oe_reg  <= 1'b0;
      wr_valid_reg <= 1'b0;
      wr_regad_reg <= 5'd0;
      wr_data_reg  <= 16'h0000;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      pre_cnt_reg  <= pre_cnt_next;
      op_reg       <= op_next;
      phyad_reg    <= phyad_next;
      regad_reg    <= regad_next;
      data_sh_reg  <= data_sh_next;
      rd_sh_reg    <= rd_sh_next;
      mdio_o_reg   <= mdio_o_next;
      mdio_oe_reg  <= mdio_oe_next;
      wr_valid_reg <= wr_valid_next;
      wr_regad_reg <= wr_regad_next;
      wr_data_reg  <= wr_data_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    pre_cnt_next  = pre_cnt_reg;
    op_next       = op_reg;
    phyad_next    = phyad_reg;
    regad_next    = regad_reg;
    data_sh_next  = data_sh_reg;
    rd_sh_next    = rd_sh_reg;
    mdio_o_next   = mdio_o_reg;
    mdio_oe_next  = mdio_oe_reg;
    wr_valid_next = 1'b0;
    wr_regad_next = wr_regad_reg;
    wr_data_next  = wr_data_reg;
    commit        = 1'b0;
    commit_data   = {data_sh_reg[14:0], mdio_bit};
    if (mdc_rise) begin
      case (state_reg)
        IDLE: begin
          if (mdio_bit) begin
            pre_cnt_next = (pre_cnt_reg == 6'h3F) ? pre_cnt_reg : pre_cnt_reg + 6'd1;
          end else begin
            pre_cnt_next = 6'd0;
            if (pre_ok) state_next = ST2;
          end
        end
        ST2: begin
          state_next   = mdio_bit ? OP : IDLE;
          bit_cnt_next = 4'd0;
        end
        OP: begin
          op_next = {op_reg[0], mdio_bit};
          if (bit_cnt_reg == 4'd1) begin
            bit_cnt_next = 4'd0;
            state_next   = (op_next == 2'b10 || op_next == 2'b01) ? PHYAD : IDLE;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end
        PHYAD: begin
          phyad_next = {phyad_reg[3:0], mdio_bit};
          if (bit_cnt_reg == 4'd4) begin
            bit_cnt_next = 4'd0;
            state_next   = REGAD;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end
        REGAD: begin
          regad_next = {regad_reg[3:0], mdio_bit};
          if (bit_cnt_reg == 4'd4) begin
            bit_cnt_next = 4'd0;
            state_next   = TA;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end
        TA: begin
          if (bit_cnt_reg == 4'd0) begin
            bit_cnt_next = 4'd1;
            // Snapshot read data here so a later write cannot alter the frame in flight.
            if (match && op_reg == 2'b10) begin
              rd_sh_next   = reg_file[regad_reg];
              mdio_oe_next = 1'b1;
              mdio_o_next  = 1'b0;
            end
          end else begin
            bit_cnt_next = 4'd0;
            state_next   = DATA;
            if (mdio_oe_reg) begin
              mdio_o_next = rd_sh_reg[15];
              rd_sh_next  = {rd_sh_reg[14:0], 1'b0};
            end
          end
        end
        DATA: begin
          data_sh_next = commit_data;
          if (bit_cnt_reg == 4'd15) begin
            bit_cnt_next = 4'd0;
            pre_cnt_next = 6'd0;
            state_next   = IDLE;
            mdio_oe_next = 1'b0;
            mdio_o_next  = 1'b1;
            if (match && op_reg == 2'b01) begin
              commit        = 1'b1;
              wr_valid_next = 1'b1;
              wr_regad_next = regad_reg;
              wr_data_next  = commit_data;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (mdio_oe_reg) begin
              mdio_o_next = rd_sh_reg[15];
              rd_sh_next  = {rd_sh_reg[14:0], 1'b0};
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.mdio_o   = mdio_o_reg;
  assign bus.mdio_oe  = mdio_oe_reg;
  assign bus.wr_valid = wr_valid_reg;
  assign bus.wr_regad = wr_regad_reg;
  assign bus.wr_data  = wr_data_reg;
  assign bus.ctrl_reg = reg_file[0];

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: bit-banged MDIO master, register model and
// read/write scoreboards.
module tb_mdio_phy_responder;
  localparam logic [4:0] PHY = 5'd1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mdio_phy_responder_if bus ();

  mdio_phy_responder #(
    .PHY_ADDR(PHY), .PHY_ID1(16'h0141), .PHY_ID2(16'h0CC2),
    .STATUS_VAL(16'h796D), .CTRL_RST(16'h1140)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  logic [15:0] model [32];
  logic [15:0] rd_q [$];
  logic [20:0] wr_q [$];
  logic [20:0] mon_exp;
  logic        wr_valid_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pre_ok(input int n);
`ifdef MDIO_PREAMBLE_CHECK_EN
    return n >= 32;
`else
    return n >= 1;
`endif
  endfunction

  function automatic void model_defaults();
    for (int i = 0; i < 32; i++) model[i] = 16'h0000;
    model[0] = 16'h1140;
    model[1] = 16'h796D;
    model[2] = 16'h0141;
    model[3] = 16'h0CC2;
  endfunction

  // Write-commit monitor: every wr_valid must match the oldest expected write.
  always @(negedge clk) begin
    if (reset_n && bus.wr_valid) begin
      check("wr_pulse_width", {31'd0, wr_valid_prev}, 32'd0);
      check("wr_expected", {31'd0, (wr_q.size() > 0)}, 32'd1);
      if (wr_q.size() > 0) begin
        mon_exp = wr_q.pop_front();
        check("wr_fields", {11'd0, bus.wr_regad, bus.wr_data}, {11'd0, mon_exp});
        $display("WR regad=%0d data=0x%04h", bus.wr_regad, bus.wr_data);
      end
    end
    wr_valid_prev <= bus.wr_valid;
  end

  task automatic mdc_bit(input logic b, output logic s_o, output logic s_oe);
    @(negedge clk);
    bus.mdc = 1'b0;
    bus.mdio_i = b;
    repeat (3) @(negedge clk);
    s_o  = bus.mdio_o;
    s_oe = bus.mdio_oe;
    @(negedge clk);
    bus.mdc = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame(input int pre_len, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] regad, input logic [15:0] wdata,
                       input bit abort, input string tag);
    logic so, soe, hdr_oe, b;
    logic [17:0] t_o, t_oe;
    logic [15:0] rdat;
    bit drive;
    drive  = (op == 2'b10) && (phy == PHY);
    hdr_oe = 1'b0;
    for (int i = 0; i < pre_len; i++) begin mdc_bit(1'b1, so, soe); hdr_oe |= soe; end
    mdc_bit(1'b0, so, soe); hdr_oe |= soe;
    mdc_bit(1'b1, so, soe); hdr_oe |= soe;
    for (int i = 1; i >= 0; i--) begin mdc_bit(op[i], so, soe); hdr_oe |= soe; end
    for (int i = 4; i >= 0; i--) begin mdc_bit(phy[i], so, soe); hdr_oe |= soe; end
    for (int i = 4; i >= 0; i--) begin mdc_bit(regad[i], so, soe); hdr_oe |= soe; end
    for (int i = 0; i < 18; i++) begin
      if (abort && i == 9) begin
        // Responder is presenting D8; pull reset in the middle of the low phase.
        @(negedge clk);
        bus.mdc = 1'b0;
        bus.mdio_i = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_d8_driving"}, {31'd0, bus.mdio_oe}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check({tag, "_rst_oe"}, {30'd0, bus.mdio_oe, bus.mdio_o}, 32'd1);
        check({tag, "_rst_ctrl"}, {16'd0, bus.ctrl_reg}, 32'h1140);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_defaults();
        if (rd_q.size() > 0) void'(rd_q.pop_front());
        $display("RD %s aborted by reset at D8", tag);
        return;
      end
      b = 1'b1;
      if (op == 2'b01) b = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : wdata[17 - i];
      mdc_bit(b, t_o[i], t_oe[i]);
    end
    repeat (2) @(negedge clk);
    if (drive) begin
      check({tag, "_hdr_oe"}, {31'd0, hdr_oe | t_oe[0]}, 32'd0);
      check({tag, "_ta2"}, {30'd0, t_oe[1], t_o[1]}, 32'd2);
      check({tag, "_data_oe"}, {31'd0, &t_oe[17:2]}, 32'd1);
      for (int k = 0; k < 16; k++) rdat[15 - k] = t_o[k + 2];
      check({tag, "_rd_q"}, {31'd0, (rd_q.size() > 0)}, 32'd1);
      if (rd_q.size() > 0) check({tag, "_rd_data"}, {16'd0, rdat}, {16'd0, rd_q.pop_front()});
      check({tag, "_post"}, {30'd0, bus.mdio_oe, bus.mdio_o}, 32'd1);
      $display("RD %s phy=%0d reg=%0d data=0x%04h", tag, phy, regad, rdat);
    end else begin
      check({tag, "_no_drive"}, {31'd0, hdr_oe | (|t_oe) | bus.mdio_oe}, 32'd0);
      $display("FRAME %s op=%b phy=%0d reg=%0d", tag, op, phy, regad);
    end
    check({tag, "_wr_done"}, wr_q.size(), 32'd0);
  endtask

  task automatic do_write(input logic [4:0] phy, input logic [4:0] regad,
                          input logic [15:0] d, input int pre_len, input string tag);
    if (pre_ok(pre_len) && phy == PHY) begin
      wr_q.push_back({regad, d});
      if (regad == 5'd0 && d[15]) model_defaults();
      else if (regad == 5'd0) model[0] = d & 16'h7FFF;
      else if (regad > 5'd3) model[regad] = d;
    end
    frame(pre_len, 2'b01, phy, regad, d, 1'b0, tag);
  endtask

  task automatic do_read(input logic [4:0] phy, input logic [4:0] regad,
                         input bit abort, input string tag);
    if (phy == PHY) rd_q.push_back(model[regad]);
    frame(32, 2'b10, phy, regad, 16'h0000, abort, tag);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.mdc = 1'b0;
    bus.mdio_i = 1'b1;
    model_defaults();
    repeat (5) @(negedge clk);
    check("rst_mdio", {30'd0, bus.mdio_oe, bus.mdio_o}, 32'd1);
    check("rst_wr_valid", {31'd0, bus.wr_valid}, 32'd0);
    check("rst_wr_regad", {27'd0, bus.wr_regad}, 32'd0);
    check("rst_wr_data", {16'd0, bus.wr_data}, 32'd0);
    check("rst_ctrl", {16'd0, bus.ctrl_reg}, 32'h1140);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    do_write(PHY, 5'd4, 16'h01E1, 32, "wr_r4");
    do_read(PHY, 5'd4, 1'b0, "rd_r4");
    do_read(PHY, 5'd2, 1'b0, "rd_id1");
    do_read(PHY, 5'd3, 1'b0, "rd_id2");
    do_write(PHY, 5'd2, 16'hFFFF, 32, "wr_ro2");
    do_read(PHY, 5'd2, 1'b0, "rd_id1_again");

    do_read(5'd5, 5'd4, 1'b0, "rd_phy5");
    do_write(5'd5, 5'd4, 16'h1234, 32, "wr_phy5");
    do_read(PHY, 5'd4, 1'b0, "rd_r4_after_phy5");

    frame(32, 2'b11, 5'h1F, 5'h1F, 16'h0000, 1'b0, "op11");
    do_read(PHY, 5'd4, 1'b0, "rd_after_op11");

    do_write(PHY, 5'd7, 16'hAAAA, 32, "wr_r7");
    do_read(PHY, 5'd7, 1'b0, "rd_r7");
    do_write(PHY, 5'd0, 16'h8000, 32, "wr_softrst");
    check("softrst_ctrl", {16'd0, bus.ctrl_reg}, 32'h1140);
    do_read(PHY, 5'd7, 1'b0, "rd_r7_cleared");
    do_read(PHY, 5'd0, 1'b0, "rd_r0");
    do_write(PHY, 5'd0, 16'h2100, 32, "wr_r0");
    check("ctrl_live", {16'd0, bus.ctrl_reg}, 32'h2100);

    do_write(PHY, 5'd5, 16'h5555, 4, "wr_short_pre");
    do_read(PHY, 5'd5, 1'b0, "rd_r5");

    do_read(PHY, 5'd0, 1'b1, "rd_abort");
    repeat (4) @(negedge clk);
    do_read(PHY, 5'd3, 1'b0, "rd_after_rst");
    do_read(PHY, 5'd0, 1'b0, "rd_r0_after_rst");

    check("rd_q_empty", rd_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
Clause-22 MDIO management responder: the PHY-side end of the mdc/mdio management bus that the NIC's MDIO master drives. It oversamples MDC in the system clock domain, decodes read/write frames addressed to its PHY address, and serves a 32 x 16-bit register file. It is used as a synthesizable PHY management model in system simulation and as a loopback target for master bring-up.

Parameters:
PHY_ADDR, 5'd1, PHY address this responder answers to
PHY_ID1, 16'h0141, value of register 2 (read-only)
PHY_ID2, 16'h0CC2, value of register 3 (read-only)
STATUS_VAL, 16'h796D, value of register 1 (read-only)
CTRL_RST, 16'h1140, reset value of register 0

Ports:
clk  in  1  system clock, required >= 4x MDC frequency
reset_n  in  1  asynchronous active-low reset
mdc  in  1  management clock from the master (asynchronous to clk)
mdio_i  in  1  mdio pad input
mdio_o  out  1  mdio pad output value
mdio_oe  out  1  mdio pad output enable (1 = responder drives)
wr_valid  out  1  one-clk pulse on a committed write
wr_regad  out  5  register address of committed write
wr_data  out  16  data of committed write
ctrl_reg  out  16  live value of register 0

Behaviour:
- Interface: one clock, clk; reset_n asynchronous, active-low. All flops clear on reset_n low, release synchronous to clk.
- Reset values: mdio_o=1, mdio_oe=0, wr_valid=0, wr_regad=0, wr_data=0, ctrl_reg=CTRL_RST; registers 4-31 = 16'h0000; FSM = IDLE.
- mdc and mdio_i each pass through a 2-flop synchronizer; MDC rising edge detected from synchronized history (sample point = 3 clk after pad edge). All bit sampling uses the synchronized mdio at the detected rising edge.
- FSM, one bit per MDC rising edge:
  IDLE: count consecutive 1s (saturating 6-bit counter, reset on any 0). On 0 with preamble satisfied -> ST2; on 0 otherwise stay in IDLE.
  ST2: expect 1 -> OP; else -> IDLE.
  OP (2 bits): 10 = read, 01 = write; 00/11 -> IDLE after 2nd bit.
  PHYAD (5 bits, MSB first), REGAD (5 bits, MSB first).
  TA (2 bits): write ignores values; read drives as below.
  DATA (16 bits, MSB first) -> IDLE, preamble counter cleared.
- Match = PHYAD equals PHY_ADDR. Non-matching frames are tracked to completion but never drive and never write.
- Read (match): mdio_oe stays 0 through TA bit 1. On the clk after the MDC rising edge sampling TA bit 1, mdio_oe=1, mdio_o=0. After each following MDC rising edge, present D15..D0 in order. After the rising edge on which D0 is sampled, mdio_oe=0, mdio_o=1. Read data is latched once at TA bit 1 (later writes do not alter an in-flight read).
- Write (match): on the clk after the 16th data bit, update the register and pulse wr_valid for 1 clk with wr_regad/wr_data (held until the next write). Writes to regs 1-3 are discarded but still pulse wr_valid.
- Register 0 bit 15 (soft reset): a write with bit15=1 restores all register defaults (ctrl_reg=CTRL_RST); bit15 always reads 0.
- Reset mid-frame: reset_n low immediately releases mdio_oe and returns to IDLE; no partial write commits.
- Master releasing MDC mid-frame is not detected; the frame completes on later edges (no timeout).

Optional Feature:
MDIO_PREAMBLE_CHECK_EN: defined -> the IDLE counter must reach 32 consecutive 1s before a start 0 is accepted; shorter preambles are ignored. Undefined -> preamble suppression: a single 1 before the start 0 suffices (counter >= 1).

Test Plan:
- 32-bit preamble, write PHYAD=1 REGAD=4 data 16'h01E1, then read REGAD=4 -> wr_valid pulse with wr_regad=4, wr_data=16'h01E1; read returns 16'h01E1, TA bit 2 driven 0, mdio_oe low after D0.
- Read REGAD=2 and 3 -> 16'h0141 and 16'h0CC2; write 16'hFFFF to REGAD=2 -> wr_valid pulses, readback still 16'h0141.
- Frame with PHYAD=5 (read and write) -> mdio_oe 0 for the entire frame, no wr_valid, reg unchanged.
- Opcode 11 followed by a valid read frame -> first frame ignored, second read returns correct data.
- Write REGAD=0 16'h8000 after writing 16'hAAAA to REGAD=7 -> ctrl_reg=16'h1140, reg 7 reads 0, reg 0 bit15 reads 0.
- Write with a 4-bit preamble -> accepted without the macro, ignored with MDIO_PREAMBLE_CHECK_EN; reset_n asserted during read D8 -> mdio_oe=0 immediately, next full read succeeds.
